pipeline_hazard_ctrl: RTL and testbench

Parametrised hazard and stall controller for the pipelined datapath. It generalises the fixed four-latch enable/reset bundle to NSTAGES pipeline latches and adds load-use/RAW detection, branch flush with deferral across memory stalls, sticky halt, and a saturating stall-cycle counter. It sits beside the datapath, takes cache handshakes and register-field compares from the pipeline, and drives every latch enable and synchronous clear plus the PC enable.

---
 rtl/pipeline_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller: latch enables, bubbles, PC enable, stall counter.
// Optional macro FORWARD_EN: forwarding datapath, only load-use stalls.
module pipeline_hazard_ctrl #(
  parameter int NSTAGES     = 4,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 32
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               dmemREN,
  input  logic               dmemWEN,
  input  logic               halt,
  input  logic               flush_req,
  input  logic [4:0]         ifid_rs,
  input  logic [4:0]         ifid_rt,
  input  logic               ifid_use_rs,
  input  logic               ifid_use_rt,
  input  logic [4:0]         idex_wsel,
  input  logic               idex_regwen,
  input  logic               idex_dmemREN,
  input  logic [4:0]         exmem_wsel,
  input  logic               exmem_regwen,
  output logic [NSTAGES-1:0] stage_en,
  output logic [NSTAGES-1:0] stage_srst,
  output logic               pc_en,
  output logic               rambusy,
  output logic [CNT_W-1:0]   stall_cycles
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e           state_q, state_d;
  logic             flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic run, mem_stall, fetch_stall, flush;
  logic idex_hit, exmem_hit, data_stall;

  assign run         = nRST && (state_q == RUN);
  assign mem_stall   = (dmemREN | dmemWEN) & ~dhit;
  assign fetch_stall = ~ihit;
  assign flush       = flush_req | flush_pend_q;

  // register $0 never creates a dependency
  assign idex_hit =
    (ifid_use_rs && ifid_rs != 5'd0 && ifid_rs == idex_wsel) ||
    (ifid_use_rt && ifid_rt != 5'd0 && ifid_rt == idex_wsel);
  assign exmem_hit =
    (ifid_use_rs && ifid_rs != 5'd0 && ifid_rs == exmem_wsel) ||
    (ifid_use_rt && ifid_rt != 5'd0 && ifid_rt == exmem_wsel);

`ifdef FORWARD_EN
  logic unused_exmem;
  assign unused_exmem = exmem_hit ^ exmem_regwen;
  assign data_stall   = idex_dmemREN & idex_regwen & idex_hit;
`else
  logic unused_idex_ren;
  assign unused_idex_ren = idex_dmemREN;
  assign data_stall = (idex_regwen & idex_hit) |
                      (exmem_regwen & exmem_hit);
`endif

  always_comb begin
    stage_en     = '0;
    stage_srst   = '0;
    pc_en        = 1'b0;
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    if (run) begin
      if (halt) state_d = HALTED;
      priority case (1'b1)
        mem_stall: begin
          stage_en[NSTAGES-1]   = 1'b1;
          stage_srst[NSTAGES-1] = 1'b1;
          if (flush_req) flush_pend_d = 1'b1;
        end
        flush: begin
          pc_en    = 1'b1;
          stage_en = '1;
          for (int i = 0; i < FLUSH_DEPTH; i++) stage_srst[i] = 1'b1;
          flush_pend_d = 1'b0;
        end
        data_stall: begin
          stage_en      = '1;
          stage_en[0]   = 1'b0;
          stage_srst[1] = 1'b1;
        end
        fetch_stall: begin
          stage_en      = '1;
          stage_srst[0] = 1'b1;
        end
        default: begin
          stage_en = '1;
          pc_en    = 1'b1;
        end
      endcase
    end
  end

  assign rambusy = run & mem_stall;

  always_comb begin
    cnt_d = cnt_q;
    if (run && !pc_en && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  assign stall_cycles = cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= RUN;
      flush_pend_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (default and CNT_W=4 instances).
module tb_pipeline_hazard_ctrl;

  logic CLK = 1'b0;
  logic nRST;
  logic ihit, dhit, ren, wen, halt, flush_req;
  logic [4:0] rs, rt, iw, ew;
  logic urs, urt, ireg, iren, ereg;
  logic ihit_s;

  logic [3:0]  stage_en, stage_srst;
  logic        pc_en, rambusy;
  logic [31:0] stall_cycles;
  logic [3:0]  en_s, srst_s;
  logic        pc_s, rb_s;
  logic [3:0]  cnt_s;

  logic [41:0] obs;
  assign obs = {stage_en, stage_srst, pc_en, rambusy, stall_cycles};

  logic [41:0] q[$];
  logic [3:0]  qs[$];
  logic [41:0] e;
  logic [3:0]  es;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl u_dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dmemREN(ren), .dmemWEN(wen), .halt(halt),
    .flush_req(flush_req),
    .ifid_rs(rs), .ifid_rt(rt),
    .ifid_use_rs(urs), .ifid_use_rt(urt),
    .idex_wsel(iw), .idex_regwen(ireg), .idex_dmemREN(iren),
    .exmem_wsel(ew), .exmem_regwen(ereg),
    .stage_en(stage_en), .stage_srst(stage_srst),
    .pc_en(pc_en), .rambusy(rambusy),
    .stall_cycles(stall_cycles)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) u_sat (
    .CLK(CLK), .nRST(nRST), .ihit(ihit_s), .dhit(1'b0),
    .dmemREN(1'b0), .dmemWEN(1'b0), .halt(1'b0),
    .flush_req(1'b0),
    .ifid_rs(5'd0), .ifid_rt(5'd0),
    .ifid_use_rs(1'b0), .ifid_use_rt(1'b0),
    .idex_wsel(5'd0), .idex_regwen(1'b0), .idex_dmemREN(1'b0),
    .exmem_wsel(5'd0), .exmem_regwen(1'b0),
    .stage_en(en_s), .stage_srst(srst_s),
    .pc_en(pc_s), .rambusy(rb_s),
    .stall_cycles(cnt_s)
  );

  function automatic logic [41:0] ex(logic [3:0] en, logic [3:0] sr,
                                     logic pc, logic rb, logic [31:0] c);
    return {en, sr, pc, rb, c};
  endfunction

  task automatic idle();
    ihit = 1; dhit = 0; ren = 0; wen = 0; halt = 0; flush_req = 0;
    rs = 0; rt = 0; iw = 0; ew = 0;
    urs = 0; urt = 0; ireg = 0; iren = 0; ereg = 0;
  endtask

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    nRST = 0; idle(); ihit_s = 1;
    repeat (2) @(negedge CLK);
    q.push_back(42'd0);
    e = q.pop_front(); checks++;
    if (obs !== e) begin
      errors++; $display("FAIL reset got %h exp %h", obs, e);
    end
    checks++;
    if (cnt_s !== 4'd0) begin
      errors++; $display("FAIL reset_sat got %0d exp 0", cnt_s);
    end
    next_cycle(); nRST = 1;
    q.push_back(ex(4'hf, 4'h0, 1, 0, 0));
    @(negedge CLK);
    e = q.pop_front(); checks++;
    if (obs !== e) begin
      errors++; $display("FAIL normal got %h exp %h", obs, e);
    end
    next_cycle();
  endtask

  task automatic test_data_stall();
    logic [5:0] st;
`ifdef FORWARD_EN
    st = 6'b000001;
`else
    st = 6'b011001;
`endif
    for (int i = 0; i < 6; i++) begin
      idle();
      case (i)
        0: begin rs = 3; urs = 1; iw = 3; ireg = 1; iren = 1; end
        1: begin rs = 3; urs = 1; iw = 3; ireg = 0; iren = 1; end
        2: begin urs = 1; ireg = 1; iren = 1; end
        3: begin rs = 3; urs = 1; iw = 3; ireg = 1; end
        4: begin rt = 7; urt = 1; ew = 7; ereg = 1; end
        default: begin rt = 7; ew = 7; ereg = 1; end
      endcase
      q.push_back(st[i] ? ex(4'he, 4'h2, 0, 0, exp_cnt)
                        : ex(4'hf, 4'h0, 1, 0, exp_cnt));
      @(negedge CLK);
      e = q.pop_front(); checks++;
      if (obs !== e) begin
        errors++; $display("FAIL data_stall[%0d] got %h exp %h", i, obs, e);
      end
      next_cycle();
      if (st[i]) exp_cnt++;
    end
  endtask

  task automatic test_fetch_stall();
    idle(); ihit = 0;
    q.push_back(ex(4'hf, 4'h1, 0, 0, exp_cnt));
    @(negedge CLK);
    e = q.pop_front(); checks++;
    if (obs !== e) begin
      errors++; $display("FAIL fetch_stall got %h exp %h", obs, e);
    end
    next_cycle(); exp_cnt++;
  endtask

  task automatic test_mem_flush();
    for (int i = 0; i < 6; i++) begin
      idle();
      ren = (i < 3) || (i == 5);
      dhit = (i == 5);
      flush_req = (i == 1);
      if (i < 3) q.push_back(ex(4'h8, 4'h8, 0, 1, exp_cnt));
      else if (i == 3) q.push_back(ex(4'hf, 4'h1, 1, 0, exp_cnt));
      else q.push_back(ex(4'hf, 4'h0, 1, 0, exp_cnt));
      @(negedge CLK);
      e = q.pop_front(); checks++;
      if (obs !== e) begin
        errors++; $display("FAIL mem_flush[%0d] got %h exp %h", i, obs, e);
      end
      next_cycle();
      if (i < 3) exp_cnt++;
    end
  endtask

  task automatic test_flush_priority();
    for (int i = 0; i < 5; i++) begin
      idle();
      case (i)
        0: begin
          flush_req = 1; ihit = 0;
          rs = 4; urs = 1; iw = 4; ireg = 1; iren = 1;
        end
        1: begin ren = 1; flush_req = 1; end
        2: flush_req = 1;
        default: ;
      endcase
      if (i == 1) q.push_back(ex(4'h8, 4'h8, 0, 1, exp_cnt));
      else if (i == 0 || i == 2) q.push_back(ex(4'hf, 4'h1, 1, 0, exp_cnt));
      else q.push_back(ex(4'hf, 4'h0, 1, 0, exp_cnt));
      @(negedge CLK);
      e = q.pop_front(); checks++;
      if (obs !== e) begin
        errors++; $display("FAIL flush_prio[%0d] got %h exp %h", i, obs, e);
      end
      next_cycle();
      if (i == 1) exp_cnt++;
    end
  endtask

  task automatic test_reset_pending();
    for (int i = 0; i < 3; i++) begin
      idle();
      if (i == 0) begin ren = 1; flush_req = 1; end
      nRST = (i != 1);
      if (i == 0) q.push_back(ex(4'h8, 4'h8, 0, 1, exp_cnt));
      else if (i == 1) q.push_back(42'd0);
      else q.push_back(ex(4'hf, 4'h0, 1, 0, 0));
      @(negedge CLK);
      e = q.pop_front(); checks++;
      if (obs !== e) begin
        errors++; $display("FAIL reset_pend[%0d] got %h exp %h", i, obs, e);
      end
      next_cycle();
      if (i == 1) exp_cnt = 0;
    end
  endtask

  task automatic test_halt();
    idle(); ihit = 0;
    q.push_back(ex(4'hf, 4'h1, 0, 0, exp_cnt));
    @(negedge CLK);
    e = q.pop_front(); checks++;
    if (obs !== e) begin
      errors++; $display("FAIL pre_halt got %h exp %h", obs, e);
    end
    next_cycle(); exp_cnt++;
    for (int i = 0; i < 6; i++) begin
      idle();
      halt = (i == 0);
      if (i == 2) begin ren = 1; ihit = 0; end
      nRST = (i != 4);
      if (i == 0) q.push_back(ex(4'hf, 4'h0, 1, 0, exp_cnt));
      else if (i == 5) q.push_back(ex(4'hf, 4'h0, 1, 0, 0));
      else if (i == 4) q.push_back(42'd0);
      else q.push_back(ex(4'h0, 4'h0, 0, 0, exp_cnt));
      @(negedge CLK);
      e = q.pop_front(); checks++;
      if (obs !== e) begin
        errors++; $display("FAIL halt[%0d] got %h exp %h", i, obs, e);
      end
      next_cycle();
    end
    exp_cnt = 0;
  endtask

  task automatic test_saturate();
    ihit_s = 0;
    for (int i = 0; i < 20; i++) begin
      qs.push_back(i > 15 ? 4'd15 : 4'(i));
      @(negedge CLK);
      es = qs.pop_front(); checks++;
      if (cnt_s !== es) begin
        errors++; $display("FAIL saturate[%0d] got %0d exp %0d", i, cnt_s, es);
      end
      next_cycle();
    end
    ihit_s = 1;
  endtask

  initial begin
    test_reset();
    test_data_stall();
    test_fetch_stall();
    test_mem_flush();
    test_flush_priority();
    test_reset_pending();
    test_halt();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
